// File: rtl/readout_pkg.sv
// Shared types and default sizing for the pixel readout requester.
package readout_pkg;

  localparam int unsigned AW_DEF     = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned TO_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/hit_fifo.sv
// Pending-hit FIFO: registered pointers/count, read head presented combinationally.
module hit_fifo #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            din,
  input  logic                     pop,
  output logic [AW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_requester.sv
// Queues pixel hits and presents them one at a time to an asynchronous
// arbiter tree over a 4-phase req/ack handshake.
module arb_requester
  import readout_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hit_vld,
  input  logic [AW-1:0]          hit_addr,
  output logic                   hit_rdy,
  output logic                   req,
  input  logic                   ack,
  output logic                   bus_vld,
  output logic [AW-1:0]          bus_addr,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   ovf,
  output logic                   to_err
);

  localparam int unsigned TW = $clog2(TO_CYC + 1);

  arb_state_e    state;
  logic          ack_m;
  logic          ack_s;
  logic [TW-1:0] phase_cnt;
  logic [1:0]    settle;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          phase_wait;
  logic [AW-1:0] head;

  assign hit_rdy    = !rst && !fifo_full;
  assign push       = hit_vld && hit_rdy;
  assign pop        = (state == ST_REQ) && ack_s;
  assign phase_wait = ((state == ST_REQ) && !ack_s) || ((state == ST_REL) && ack_s);

  hit_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (hit_addr),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) {ack_s, ack_m} <= 2'b00;
    else     {ack_s, ack_m} <= {ack_m, ack};
  end

  always_ff @(posedge clk) begin
    if (rst)                        ovf <= 1'b0;
    else if (hit_vld && fifo_full)  ovf <= 1'b1;
  end

  // Phase counter is zero whenever a wait is not in progress, so every state entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
      to_err    <= 1'b0;
    end else if (!phase_wait) begin
      phase_cnt <= '0;
    end else begin
      if (phase_cnt != TW'(TO_CYC)) phase_cnt <= phase_cnt + TW'(1);
      if (phase_cnt == TW'(TO_CYC - 1)) to_err <= 1'b1;
    end
  end

  // settle holds off the first request until the synchronizer has sampled the live ack after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      bus_vld  <= 1'b0;
      bus_addr <= '0;
      settle   <= 2'd0;
    end else begin
      bus_vld <= 1'b0;
      if (settle != 2'd2) settle <= settle + 2'd1;
      case (state)
        ST_IDLE: begin
          if ((settle == 2'd2) && !fifo_empty && !ack_s) begin
            state <= ST_REQ;
            req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            state    <= ST_REL;
            req      <= 1'b0;
            bus_vld  <= 1'b1;
            bus_addr <= head;
          end
        end
        ST_REL: begin
          if (!ack_s) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios plus random traffic against a cycle model.
module tb_arb_requester;

  localparam int unsigned AW     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TO_CYC = 16;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hit_vld;
  logic [AW-1:0] hit_addr;
  logic          hit_rdy;
  logic          req;
  logic          ack;
  logic          bus_vld;
  logic [AW-1:0] bus_addr;
  logic [CW-1:0] pend_cnt;
  logic          ovf;
  logic          to_err;

  arb_requester #(.AW(AW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .hit_vld  (hit_vld),
    .hit_addr (hit_addr),
    .hit_rdy  (hit_rdy),
    .req      (req),
    .ack      (ack),
    .bus_vld  (bus_vld),
    .bus_addr (bus_addr),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
    .to_err   (to_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted hits plus handshake phase (0 idle, 1 requesting, 2 releasing).
  logic [AW-1:0] mq[$];
  int            m_phase, m_cnt, m_since;
  logic          m_a1, m_a2, m_req, m_bus_vld, m_ovf, m_to;
  logic [AW-1:0] m_bus_addr;

  logic [AW-1:0] dut_grants[$];
  bit            auto_en;
  int            g_delay, g_hold, a_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_cnt = 0; m_since = 0;
    m_a1 = 0; m_a2 = 0; m_req = 0; m_bus_vld = 0; m_ovf = 0; m_to = 0;
    m_bus_addr = '0;
  endtask

  task automatic wait_tick();
    if (m_cnt < int'(TO_CYC)) m_cnt++;
    if (m_cnt == int'(TO_CYC)) m_to = 1;
  endtask

  task automatic model_edge();
    bit full;
    if (rst) begin
      model_reset();
      return;
    end
    full = (mq.size() == int'(DEPTH));
    m_bus_vld = 0;
    case (m_phase)
      0: if (m_since >= 2 && mq.size() != 0 && !m_a2) begin
           m_phase = 1; m_req = 1; m_cnt = 0;
         end
      1: if (m_a2) begin
           m_bus_addr = mq.pop_front();
           m_bus_vld = 1; m_req = 0; m_phase = 2; m_cnt = 0;
         end else wait_tick();
      default: if (!m_a2) begin
           m_phase = 0; m_cnt = 0;
         end else wait_tick();
    endcase
    if (hit_vld) begin
      if (full) m_ovf = 1;
      else mq.push_back(hit_addr);
    end
    m_a2 = m_a1;
    m_a1 = ack;
    if (m_since < 2) m_since++;
  endtask

  // Arbiter-side responder driven from the model's view of req.
  task automatic agent();
    if (!auto_en) return;
    if (!ack) begin
      if (m_req) begin
        if (a_cnt >= g_delay) begin ack = 1; a_cnt = 0; end
        else a_cnt++;
      end else a_cnt = 0;
    end else if (!m_req) begin
      if (a_cnt >= g_hold) begin ack = 0; a_cnt = 0; end
      else a_cnt++;
    end
  endtask

  task automatic cyc();
    agent();
    @(posedge clk);
    model_edge();
    #1;
    if (bus_vld === 1'b1) dut_grants.push_back(bus_addr);
    chk("req",      32'(req),      32'(m_req));
    chk("bus_vld",  32'(bus_vld),  32'(m_bus_vld));
    chk("bus_addr", 32'(bus_addr), 32'(m_bus_addr));
    chk("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
    chk("hit_rdy",  32'(hit_rdy),  32'(!rst && mq.size() != int'(DEPTH)));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("to_err",   32'(to_err),   32'(m_to));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push1(input logic [AW-1:0] a);
    hit_vld = 1; hit_addr = a;
    cyc();
    hit_vld = 0;
  endtask

  initial begin
    model_reset();
    rst = 1; hit_vld = 1; hit_addr = 8'hEE; ack = 0;
    auto_en = 0; g_delay = 0; g_hold = 0; a_cnt = 0;

    // Reset with a hit offered: must be ignored, hit_rdy low.
    run(3);
    chk("rst_pend", 32'(pend_cnt), 32'(0));
    chk("rst_rdy",  32'(hit_rdy),  32'(0));
    rst = 0; hit_vld = 0;
    run(4);

    // Minimum latency plus single grant of 0x3A, ack 4 cycles after req rise.
    auto_en = 1; g_delay = 3; g_hold = 0;
    dut_grants.delete();
    push1(8'h3A);
    chk("pend_after_push", 32'(pend_cnt), 32'(1));
    cyc();
    chk("req_latency", 32'(req), 32'(1));
    run(15);
    chk("g35_cnt",  32'(dut_grants.size()), 32'(1));
    if (dut_grants.size() == 1) chk("g35_addr", 32'(dut_grants[0]), 32'(8'h3A));
    chk("g35_pend", 32'(pend_cnt), 32'(0));

    // Overflow: 5 back-to-back hits into a 4-deep FIFO with ack withheld.
    auto_en = 0; ack = 0;
    dut_grants.delete();
    for (int i = 1; i <= 5; i++) begin
      hit_vld = 1; hit_addr = AW'(i);
      cyc();
      if (i == 4) chk("full_rdy", 32'(hit_rdy), 32'(0));
    end
    hit_vld = 0;
    chk("ovf_set", 32'(ovf), 32'(1));
    auto_en = 1; g_delay = 1; g_hold = 1;
    run(50);
    chk("ord_cnt", 32'(dut_grants.size()), 32'(4));
    for (int i = 0; i < dut_grants.size() && i < 4; i++)
      chk("ord_addr", 32'(dut_grants[i]), 32'(i + 1));

    // Long ack hold after grant: return-to-zero enforced.
    g_delay = 0; g_hold = 10;
    push1(8'hA1);
    push1(8'hA2);
    run(50);

    // Timeout: ack never comes for a while.
    auto_en = 0; ack = 0;
    push1(8'h55);
    run(18);
    chk("to_err_set", 32'(to_err), 32'(1));
    chk("to_req_hi",  32'(req),    32'(1));
    auto_en = 1; g_delay = 0; g_hold = 0;
    run(12);
    chk("to_done_pend", 32'(pend_cnt), 32'(0));

    // Reset mid-handshake with three queued hits and ack high.
    auto_en = 0; ack = 0;
    push1(8'hC1);
    push1(8'hC2);
    push1(8'hC3);
    ack = 1;
    cyc();
    rst = 1; hit_vld = 1; hit_addr = 8'hDD;
    run(2);
    rst = 0; hit_vld = 0;
    push1(8'h77);
    run(4);
    chk("rst_hs_req", 32'(req), 32'(0));
    ack = 0;
    auto_en = 1; g_delay = 2; g_hold = 0;
    run(14);

    // Random traffic: concurrent push/pop and pointer wrap over many transactions.
    for (int blk = 0; blk < 10; blk++) begin
      g_delay = $urandom_range(0, 3);
      g_hold  = $urandom_range(0, 3);
      for (int i = 0; i < 20; i++) begin
        hit_vld  = ($urandom_range(0, 2) != 0);
        hit_addr = AW'($urandom);
        cyc();
      end
    end
    hit_vld = 0;
    run(40);
    chk("drain_pend", 32'(pend_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter AW, default 8, pixel hit address width.
REQ-002 Parameter DEPTH, default 4, pending-hit FIFO depth (power of two, >=2).
REQ-003 Parameter TO_CYC, default 255, handshake timeout in clk cycles.
REQ-004 clk  in  1  single rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hit_vld  in  1  new hit offered by pixel front-end.
REQ-007 hit_addr  in  AW  address of offered hit.
REQ-008 hit_rdy  out  1  FIFO can accept a hit (= not full).
REQ-009 req  out  1  registered request to arbiter-cell tree (4-phase).
REQ-010 ack  in  1  asynchronous grant from arbiter tree.
REQ-011 bus_vld  out  1  one-cycle strobe, granted hit on bus.
REQ-012 bus_addr  out  AW  address of granted hit, valid while bus_vld.
REQ-013 pend_cnt  out  $clog2(DEPTH)+1  number of queued hits.
REQ-014 ovf  out  1  sticky: hit offered while FIFO full.
REQ-015 to_err  out  1  sticky: handshake phase exceeded TO_CYC.

Function
REQ-016 ack SHALL pass through a 2-flop synchronizer; ack_s denotes its output; all decisions use ack_s only.
REQ-017 Hit SHALL be written when hit_vld && hit_rdy; hit_rdy = (pend_cnt != DEPTH); no write-through bypass.
REQ-018 hit_vld && !hit_rdy SHALL set ovf and drop the hit; FIFO contents unchanged.
REQ-019 Simultaneous write and pop SHALL keep pend_cnt unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states: IDLE, REQ, REL.
REQ-021 IDLE -> REQ when pend_cnt != 0 && ack_s == 0; req = 1 from the next cycle.
REQ-022 REQ: req held 1; on ack_s == 1 -> REL, same edge pops FIFO head into bus_addr and sets bus_vld for exactly one cycle.
REQ-023 REL: req = 0; on ack_s == 0 -> IDLE; no new request while ack_s high (return-to-zero enforced).
REQ-024 req SHALL never rise while ack_s == 1 and never fall while in REQ before ack_s == 1.
REQ-025 Phase counter SHALL clear on each state entry, count in REQ and REL, saturate at TO_CYC; reaching TO_CYC sets to_err; FSM keeps waiting (no abort).
REQ-026 Minimum handshake: hit written cycle 0 -> req high cycle 2 -> ack rising at cycle n -> bus_vld at n+3 (2 sync + registered).
REQ-027 bus_addr SHALL hold last granted address when bus_vld == 0.
REQ-028 Order of grants SHALL be FIFO order of accepted hits.

Reset
REQ-029 On rst: FSM = IDLE, req = 0, bus_vld = 0, bus_addr = 0, pointers and pend_cnt = 0, ovf = 0, to_err = 0, synchronizer flops = 0, phase counter = 0.
REQ-030 Reset mid-handshake SHALL discard queued hits; after release, no req until ack_s observed 0 (REQ-021 guard).
REQ-031 hit_vld during rst SHALL be ignored; hit_rdy = 0 while rst high.

Structure
REQ-032 State encoding enum and default AW/DEPTH/TO_CYC constants SHALL live in shared package readout_pkg.
REQ-033 FIFO SHALL be one sub-module, hit_fifo (push/pop/full/empty/count); synchronizer and FSM inline.
REQ-034 Implementation fully synchronous RTL; no switch primitives, no latches, no combinational path ack -> req.

Verification
REQ-035 Single hit 0x3A, ack responds 4 cycles after req rise -> bus_vld one cycle with bus_addr 0x3A, req falls same edge, pend_cnt 1 -> 0.
REQ-036 Push 5 hits 0x01..0x05 back-to-back, DEPTH 4, ack withheld -> hit_rdy low after 4th, ovf = 1, grants later deliver 0x01..0x04 in order.
REQ-037 ack held high 10 cycles after grant -> req stays 0 in REL until ack_s low, next req no earlier than 1 cycle after IDLE entry.
REQ-038 ack never asserted, TO_CYC = 16 -> to_err = 1 at 16 cycles in REQ, req still 1; later ack completes normally.
REQ-039 rst asserted while REQ with 3 queued hits and ack high -> req 0, pend_cnt 0, no req until ack low for 2+ cycles.
REQ-040 Push and grant-pop on same cycle with pend_cnt 2 -> pend_cnt stays 2, pointer wrap at DEPTH verified over 10 transactions.
